psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Downstream of the combinational adder tree in the LeNet5 DSP datapath.
- Consumes one signed partial sum per accepted beat and accumulates a configurable number of beats per output pixel, seeded with a bias.
- Emits one requantized signed result per group: rounded arithmetic right shift, then saturation, on a valid/ready handshake.

Parameters:
- IN_WIDTH, 32, width of signed partial sum from the adder tree
- ACC_WIDTH, 40, signed accumulator width; must be >= IN_WIDTH
- BIAS_WIDTH, 16, signed bias width
- OUT_WIDTH, 8, signed output width
- SHIFT, 4, requantization right-shift amount (0..ACC_WIDTH-1)
- CNT_WIDTH, 9, beat-count width; a group holds at most 2^CNT_WIDTH-1 beats

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_beats  in  CNT_WIDTH  beats per group; sampled on the first beat of a group; 0 is treated as 1
- cfg_bias  in  BIAS_WIDTH  signed bias; sampled on the first beat of a group
- in_valid  in  1  partial sum valid
- in_ready  out  1  block can accept a partial sum
- in_psum  in  IN_WIDTH  signed partial sum
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_WIDTH  signed requantized result
- out_ovf  out  1  saturation occurred for this result
- busy  out  1  a group is in progress (state != IDLE)

Behaviour:
- Reset: all state is cleared on a clk edge with rst_n=0.
  - State goes to IDLE; accumulator, count and latched beats are cleared.
  - out_valid=0, out_data=0, out_ovf=0, busy=0, in_ready=0 while rst_n=0.
  - Reset mid-group discards the partial accumulation; no output is produced for it.
- Handshake: a beat transfers when in_valid && in_ready at a clk edge. A result transfers when out_valid && out_ready.
- in_ready is decoded from state only: 1 in IDLE and ACC, 0 in OUT. It does not depend on in_valid.
- FSM states:
  - IDLE:
    - On a transfer: acc <= sext(cfg_bias) + sext(in_psum); latch beats = max(cfg_beats,1); cnt <= 1.
    - Go to OUT if beats==1, else go to ACC.
  - ACC:
    - On each transfer: acc <= acc + sext(in_psum); cnt <= cnt+1.
    - The transfer with cnt==beats-1 moves to OUT. Idle cycles hold state.
  - OUT:
    - out_valid=1 and out_data/out_ovf are registered and stable until the handshake.
    - On out_ready go to IDLE. No new beat is accepted in the same cycle (one bubble per group).
- Arithmetic:
  - The accumulator wraps in two's complement at ACC_WIDTH; no accumulator overflow detection.
  - Requantization: r = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, computed in ACC_WIDTH+1 bits (round half up).
  - Saturation: clamp r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; out_ovf=1 iff clamping occurred.
- Latency: out_valid rises on the clk edge after the last beat transfers. Minimum group period is beats+1 cycles.
- cfg_beats/cfg_bias changes mid-group have no effect on that group.
- out_valid is never dropped without out_ready.

Optional Feature:
- Macro PSUM_ACC_RELU_EN.
- Defined: after rounding, r<0 is clamped to 0 before saturation; out_ovf is not set by this clamp, only by upper-bound saturation.
- Undefined: signed output as described in Behaviour; negative values pass through, with saturation at the lower bound.

Test Plan:
- Basic accumulate: beats=3, bias=16, psums 16,32,48 back-to-back -> acc=112, out_data=7, out_ovf=0, out_valid one cycle after the 3rd beat.
- Saturation: beats=1, bias=0, psum=5000 -> out_data=127, out_ovf=1. Then psum=-5000 -> out_data=-128, out_ovf=1; with PSUM_ACC_RELU_EN -> out_data=0, out_ovf=0.
- Rounding: beats=1, bias=0, psums -8, -9, 7, 8 in separate groups -> 0, -1, 0, 1.
- Backpressure: out_ready=0 for 5 cycles with in_valid held high -> in_ready=0, out_data/out_ovf stable, no extra beats accepted. Next group result is correct after out_ready=1.
- Gapped input and cfg change: beats=4, bias=-3, psums 1,2,3,4 with in_valid low 2 cycles between beats; cfg_beats changed to 1 mid-group -> 4 beats still consumed, acc=7, out_data=0; busy=1 throughout the group.
- Reset mid-group: 2 of 4 beats accepted, rst_n=0 for one edge -> out_valid=0, busy=0. A new group beats=1, bias=0, psum=32 -> out_data=2.

Source files
------------

// File: rtl/psum_accumulator_if.sv
// Stream/config bundle between the adder tree, the psum accumulator and the consumer.
// master: drives config, input beats and out_ready (upstream/testbench side).
// slave : the accumulator; drives in_ready, result stream and busy.
interface psum_accumulator_if #(
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned BIAS_WIDTH = 16,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH  = 9
);
    logic [CNT_WIDTH-1:0]  cfg_beats;
    logic [BIAS_WIDTH-1:0] cfg_bias;
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_WIDTH-1:0]   in_psum;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_ovf;
    logic                  busy;

    modport master (
        output cfg_beats, cfg_bias, in_valid, in_psum, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        input  cfg_beats, cfg_bias, in_valid, in_psum, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums cfg_beats signed partial sums per output pixel on
// top of a bias, then emits a rounded (half up), right-shifted, saturated result.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   bus (slave modport)  cfg_beats/cfg_bias (sampled on first beat), in_valid/in_ready/
//                        in_psum input stream, out_valid/out_ready/out_data/out_ovf
//                        result stream, busy (group in progress)
// Build option: define PSUM_ACC_RELU_EN to clamp negative results to zero.
module psum_accumulator #(
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned BIAS_WIDTH = 16,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned SHIFT      = 4,
    parameter int unsigned CNT_WIDTH  = 9
) (
    input logic               clk,
    input logic               rst_n,
    psum_accumulator_if.slave bus
);
    localparam int unsigned RW = ACC_WIDTH + 1;
    // 2^(SHIFT-1), or 0 when SHIFT is 0
    localparam logic [RW-1:0] RND = (RW'(1) << SHIFT) >> 1;
    localparam logic signed [RW-1:0] OMAX = signed'((RW'(1) << (OUT_WIDTH - 1)) - RW'(1));
`ifndef PSUM_ACC_RELU_EN
    localparam logic signed [RW-1:0] OMIN = ~OMAX;
`endif

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                state;
    logic [ACC_WIDTH-1:0]  acc;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  beats;
    logic                  out_valid_q;
    logic [OUT_WIDTH-1:0]  out_data_q;
    logic                  out_ovf_q;
    logic                  busy_q;

    logic                  in_fire;
    logic [CNT_WIDTH-1:0]  beats_eff;
    logic [ACC_WIDTH-1:0]  acc_base;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic signed [RW-1:0]  rnd_sum;
    logic signed [RW-1:0]  shifted;
    logic [OUT_WIDTH-1:0]  sat_data;
    logic                  sat_ovf;

    // Ready is a pure state decode, forced low while reset is asserted
    assign bus.in_ready = rst_n && (state != OUT);
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign beats_eff    = (bus.cfg_beats == '0) ? CNT_WIDTH'(1) : bus.cfg_beats;

    // Next accumulator value; the first beat of a group starts from the bias
    always_comb begin
        acc_base = (state == IDLE) ? ACC_WIDTH'($signed(bus.cfg_bias)) : acc;
        acc_next = acc_base + ACC_WIDTH'($signed(bus.in_psum));
    end

    // Requantize the value the accumulator will hold after this beat
    always_comb begin
        rnd_sum  = {acc_next[ACC_WIDTH-1], acc_next} + RND;
        shifted  = rnd_sum >>> SHIFT;
        sat_data = shifted[OUT_WIDTH-1:0];
        sat_ovf  = 1'b0;
`ifdef PSUM_ACC_RELU_EN
        if (shifted[RW-1]) begin
            sat_data = '0;
        end else if (shifted > OMAX) begin
            sat_data = OMAX[OUT_WIDTH-1:0];
            sat_ovf  = 1'b1;
        end
`else
        if (shifted > OMAX) begin
            sat_data = OMAX[OUT_WIDTH-1:0];
            sat_ovf  = 1'b1;
        end else if (shifted < OMIN) begin
            sat_data = OMIN[OUT_WIDTH-1:0];
            sat_ovf  = 1'b1;
        end
`endif
    end

    // Group FSM with registered result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            beats       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        acc    <= acc_next;
                        cnt    <= CNT_WIDTH'(1);
                        beats  <= beats_eff;
                        busy_q <= 1'b1;
                        if (beats_eff == CNT_WIDTH'(1)) begin
                            state       <= OUT;
                            out_valid_q <= 1'b1;
                            out_data_q  <= sat_data;
                            out_ovf_q   <= sat_ovf;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (in_fire) begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_WIDTH'(1);
                        if (cnt == beats - CNT_WIDTH'(1)) begin
                            state       <= OUT;
                            out_valid_q <= 1'b1;
                            out_data_q  <= sat_data;
                            out_ovf_q   <= sat_ovf;
                        end
                    end
                end
                OUT: begin
                    // No beat is taken here: one bubble cycle per group
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator (default parameters).
// Define PSUM_ACC_RELU_EN for both bench and RTL to check the ReLU build.
module tb_psum_accumulator;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    psum_accumulator_if #(
        .IN_WIDTH(32), .BIAS_WIDTH(16), .OUT_WIDTH(8), .CNT_WIDTH(9)
    ) bus ();

    psum_accumulator #(
        .IN_WIDTH(32), .ACC_WIDTH(40), .BIAS_WIDTH(16),
        .OUT_WIDTH(8), .SHIFT(4), .CNT_WIDTH(9)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One single-beat (or cfg_beats=0) group, result read then drained
    task automatic run_single(input string tag, input logic [8:0] beats,
                              input int bias, input int psum,
                              input int exp_d, input logic exp_o);
        bus.cfg_beats = beats;
        bus.cfg_bias  = 16'(bias);
        bus.in_psum   = 32'(psum);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_data"}, $signed(bus.out_data), exp_d);
        check({tag, "_ovf"}, bus.out_ovf, exp_o);
        tick();
        check({tag, "_drained"}, bus.out_valid, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cfg_beats = '0;
        bus.cfg_bias  = '0;
        bus.in_valid  = 1'b0;
        bus.in_psum   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_ovf", bus.out_ovf, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("idle_ready", bus.in_ready, 1);

        // Basic accumulate: 16 + 16 + 32 + 48 = 112 -> (112+8)>>4 = 7
        bus.out_ready = 1'b1;
        bus.cfg_beats = 9'd3;
        bus.cfg_bias  = 16'sd16;
        bus.in_valid  = 1'b1;
        bus.in_psum   = 32'sd16;
        tick();
        check("basic_busy", bus.busy, 1);
        bus.in_psum = 32'sd32;
        tick();
        check("basic_not_yet", bus.out_valid, 0);
        bus.in_psum = 32'sd48;
        tick();
        bus.in_valid = 1'b0;
        check("basic_valid", bus.out_valid, 1);
        check("basic_data", $signed(bus.out_data), 7);
        check("basic_ovf", bus.out_ovf, 0);
        check("basic_out_ready", bus.in_ready, 0);
        tick();
        check("basic_drained", bus.out_valid, 0);
        check("basic_idle", bus.busy, 0);

        // Saturation and boundaries around +127 / -128
        run_single("sat_pos", 9'd1, 0, 5000, 127, 1'b1);
        run_single("edge_127", 9'd1, 0, 2032, 127, 1'b0);
        run_single("edge_128", 9'd1, 0, 2040, 127, 1'b1);
`ifdef PSUM_ACC_RELU_EN
        run_single("sat_neg", 9'd1, 0, -5000, 0, 1'b0);
        run_single("edge_m128", 9'd1, 0, -2048, 0, 1'b0);
        run_single("edge_m129", 9'd1, 0, -2057, 0, 1'b0);
`else
        run_single("sat_neg", 9'd1, 0, -5000, -128, 1'b1);
        run_single("edge_m128", 9'd1, 0, -2048, -128, 1'b0);
        run_single("edge_m129", 9'd1, 0, -2057, -128, 1'b1);
`endif

        // Rounding half up
        run_single("rnd_m8", 9'd1, 0, -8, 0, 1'b0);
`ifdef PSUM_ACC_RELU_EN
        run_single("rnd_m9", 9'd1, 0, -9, 0, 1'b0);
`else
        run_single("rnd_m9", 9'd1, 0, -9, -1, 1'b0);
`endif
        run_single("rnd_7", 9'd1, 0, 7, 0, 1'b0);
        run_single("rnd_8", 9'd1, 0, 8, 1, 1'b0);
        // cfg_beats = 0 behaves as a single beat, bias applied: (16+16+8)>>4 = 2
        run_single("beats0", 9'd0, 16, 16, 2, 1'b0);

        // Backpressure: (100+8)>>4 = 6 held while in_valid stays high
        bus.out_ready = 1'b0;
        bus.cfg_beats = 9'd1;
        bus.cfg_bias  = '0;
        bus.in_valid  = 1'b1;
        bus.in_psum   = 32'sd100;
        tick();
        bus.in_psum = 32'sd999;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", bus.in_ready, 0);
            check("bp_valid", bus.out_valid, 1);
            check("bp_data", $signed(bus.out_data), 6);
            check("bp_ovf", bus.out_ovf, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_released", bus.out_valid, 0);
        // Next group: 2 beats of 40 -> (80+8)>>4 = 5
        bus.cfg_beats = 9'd2;
        bus.in_psum   = 32'sd40;
        tick();
        check("bp_next_mid", bus.out_valid, 0);
        tick();
        bus.in_valid = 1'b0;
        check("bp_next_valid", bus.out_valid, 1);
        check("bp_next_data", $signed(bus.out_data), 5);
        tick();

        // Gapped beats with cfg change mid-group: -3+1+2+3+4 = 7 -> 0
        bus.cfg_beats = 9'd4;
        bus.cfg_bias  = -16'sd3;
        for (int b = 1; b <= 4; b++) begin
            bus.in_valid = 1'b1;
            bus.in_psum  = 32'(b);
            tick();
            bus.in_valid = 1'b0;
            bus.cfg_beats = 9'd1;
            bus.cfg_bias  = 16'sd100;
            if (b < 4) begin
                for (int g = 0; g < 2; g++) begin
                    check("gap_busy", bus.busy, 1);
                    check("gap_no_valid", bus.out_valid, 0);
                    tick();
                end
            end
        end
        check("gap_valid", bus.out_valid, 1);
        check("gap_data", $signed(bus.out_data), 0);
        check("gap_ovf", bus.out_ovf, 0);
        check("gap_busy_out", bus.busy, 1);
        tick();
        check("gap_idle", bus.busy, 0);

        // Reset mid-group discards the partial sum
        bus.cfg_beats = 9'd4;
        bus.cfg_bias  = '0;
        bus.in_valid  = 1'b1;
        bus.in_psum   = 32'sd100;
        tick();
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("mrst_valid", bus.out_valid, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        run_single("mrst_after", 9'd1, 0, 32, 2, 1'b0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
